// File: rtl/processor_pkg.sv
// Shared definitions for the processor core: opcode and funct codes, the ALU
// operation enum and helpers that assemble R/I-type instruction words so the
// ROM can be written in mnemonic form rather than as raw hex.
package processor_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct7 values: BASE for the plain op, ALT selects SUB / SRA / SRAI.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_R};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, OP_IMM};
  endfunction

endpackage

// File: rtl/processor_if.sv
// ALU operand/result bundle between the core's decode stage and the ALU.
//   a, b    : operands (b is rs2 or the sign-extended immediate)
//   alu_op  : operation select
//   result  : combinational ALU result
// master drives operands, slave (the ALU) returns the result.
interface processor_if;
  import processor_pkg::*;

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  alu_op_e         alu_op;
  logic [XLEN-1:0] result;

  modport master (output a, output b, output alu_op, input result);
  modport slave  (input a, input b, input alu_op, output result);
endinterface

// File: rtl/processor_alu.sv
// Purely combinational RV32I integer ALU.
//   bus.a, bus.b, bus.alu_op : inputs
//   bus.result               : output
// Shift amount is always b[4:0]; for immediate shifts the decoder places
// instr[24:20] there via the sign-extended immediate.
module alu
  import processor_pkg::*;
(
  processor_if.slave bus
);

  logic [4:0] shamt;

  always_comb begin
    shamt      = bus.b[4:0];
    bus.result = '0;
    case (bus.alu_op)
      ALU_ADD:  bus.result = bus.a + bus.b;
      ALU_SUB:  bus.result = bus.a - bus.b;
      ALU_SLL:  bus.result = bus.a << shamt;
      ALU_SLT:  bus.result = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      ALU_SLTU: bus.result = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
      ALU_XOR:  bus.result = bus.a ^ bus.b;
      ALU_SRL:  bus.result = bus.a >> shamt;
      ALU_SRA:  bus.result = $unsigned($signed(bus.a) >>> shamt);
      ALU_OR:   bus.result = bus.a | bus.b;
      ALU_AND:  bus.result = bus.a & bus.b;
      default:  bus.result = '0;
    endcase
  end

endmodule

// File: rtl/processor.sv
// Single-cycle RV32I ALU-subset core with a hard-coded instruction ROM.
// Each rising clk executes the instruction at pc and writes rd.
//   clk : system clock
//   rst : asynchronous active-low reset (clears pc and x1..x31)
//   res : ALU result of the instruction at pc, 0 in reset or for
//         unsupported opcodes/encodings
module processor
  import processor_pkg::*;
#(
  parameter int IMEM_DEPTH = 32,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] res
);

  localparam int AW   = $clog2(IMEM_DEPTH);
  localparam int PC_W = AW + 2;
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);
  localparam logic [31:0]     NOP     = 32'h0000_0013;

  // pc only spans the ROM, so incrementing past the end wraps to 0.
  logic [PC_W-1:0] pc_q, pc_d;
  logic [XLEN-1:0] regs_q [32];

  logic [31:0]     instr;
  logic [6:0]      opcode, f7;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_sext, rs1_val, rs2_val, op_b;
  alu_op_e         alu_op;
  logic            legal, wr_en;

  processor_if alu_bus ();

  function automatic logic [31:0] rom_word(input logic [AW-1:0] idx);
    case (int'(idx))
      0:       return enc_r(F7_BASE, 5'd0,  5'd0,  F3_AND,  5'd1);
      1:       return enc_i(12'd3,          5'd0,  F3_ADD,  5'd1);
      2:       return enc_i(12'd2,          5'd0,  F3_ADD,  5'd2);
      3:       return enc_r(F7_BASE, 5'd1,  5'd1,  F3_ADD,  5'd3);
      4:       return enc_r(F7_BASE, 5'd1,  5'd3,  F3_OR,   5'd4);
      5:       return enc_r(F7_BASE, 5'd2,  5'd2,  F3_SLL,  5'd5);
      6:       return enc_r(F7_BASE, 5'd3,  5'd4,  F3_ADD,  5'd6);
      7:       return enc_r(F7_BASE, 5'd5,  5'd6,  F3_AND,  5'd7);
      8:       return enc_r(F7_ALT,  5'd5,  5'd7,  F3_ADD,  5'd8);
      9:       return enc_r(F7_ALT,  5'd2,  5'd5,  F3_SRL,  5'd9);
      10:      return enc_i(12'd5,          5'd9,  F3_OR,   5'd10);
      11:      return enc_r(F7_BASE, 5'd10, 5'd9,  F3_SLT,  5'd11);
      12:      return enc_i(12'hFF2,        5'd0,  F3_ADD,  5'd12);
      13:      return enc_r(F7_BASE, 5'd12, 5'd9,  F3_SLTU, 5'd13);
      14:      return enc_i(12'h725,        5'd12, F3_XOR,  5'd14);
      15:      return enc_i(12'h000,        5'd14, F3_SLT,  5'd15);
      16:      return enc_i(12'd590,        5'd14, F3_ADD,  5'd16);
      17:      return enc_i({F7_BASE, 5'd4}, 5'd1, F3_SLL,  5'd17);
      default: return NOP;
    endcase
  endfunction

  always_comb begin
    instr    = rom_word(pc_q[PC_W-1:2]);
    opcode   = instr[6:0];
    rd       = instr[11:7];
    f3       = instr[14:12];
    rs1      = instr[19:15];
    rs2      = instr[24:20];
    f7       = instr[31:25];
    imm_sext = {{(XLEN-12){instr[31]}}, instr[31:20]};
    rs1_val  = (rs1 == 5'd0) ? '0 : regs_q[rs1];
    rs2_val  = (rs2 == 5'd0) ? '0 : regs_q[rs2];
  end

  // Decode. Only exact funct7 encodings are accepted; anything else is
  // treated like an unsupported opcode (no writeback, res=0).
  always_comb begin
    alu_op = ALU_ADD;
    op_b   = rs2_val;
    legal  = 1'b0;
    if (opcode == OP_R) begin
      legal = (f7 == F7_BASE);
      case (f3)
        F3_ADD: begin
          alu_op = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          legal  = (f7 == F7_BASE) || (f7 == F7_ALT);
        end
        F3_SRL: begin
          alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          legal  = (f7 == F7_BASE) || (f7 == F7_ALT);
        end
        F3_SLL:  alu_op = ALU_SLL;
        F3_SLT:  alu_op = ALU_SLT;
        F3_SLTU: alu_op = ALU_SLTU;
        F3_XOR:  alu_op = ALU_XOR;
        F3_OR:   alu_op = ALU_OR;
        F3_AND:  alu_op = ALU_AND;
        default: legal  = 1'b0;
      endcase
    end else if (opcode == OP_IMM) begin
      op_b  = imm_sext;
      legal = 1'b1;
      case (f3)
        F3_ADD:  alu_op = ALU_ADD;
        F3_SLT:  alu_op = ALU_SLT;
        F3_SLTU: alu_op = ALU_SLTU;
        F3_XOR:  alu_op = ALU_XOR;
        F3_OR:   alu_op = ALU_OR;
        F3_AND:  alu_op = ALU_AND;
        F3_SLL: begin
          alu_op = ALU_SLL;
          legal  = (f7 == F7_BASE);
        end
        F3_SRL: begin
          alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          legal  = (f7 == F7_BASE) || (f7 == F7_ALT);
        end
        default: legal = 1'b0;
      endcase
    end
  end

  assign alu_bus.a      = rs1_val;
  assign alu_bus.b      = op_b;
  assign alu_bus.alu_op = alu_op;

  alu u_alu (
    .bus (alu_bus.slave)
  );

  // res and writeback are gated by rst so the output drops to 0 the moment
  // reset is asserted, not at the next edge.
  assign wr_en = legal && rst;
  assign res   = wr_en ? alu_bus.result : '0;
  assign pc_d  = pc_q + PC_STEP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (wr_en && (rd != 5'd0)) regs_q[rd] <= alu_bus.result;
    end
  end

endmodule

// File: tb/tb_processor.sv
module tb_processor;

  logic        clk;
  logic        rst;
  logic [31:0] res;

  int checks = 0;
  int errors = 0;

  processor dut (
    .clk (clk),
    .rst (rst),
    .res (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- architectural reference model ----------------
  typedef enum int {K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND} kind_e;

  kind_e       p_kind [32];
  int          p_rd   [32];
  int          p_rs1  [32];
  int          p_rs2  [32];
  logic [31:0] p_imm  [32];
  bit          p_isimm[32];
  logic [31:0] spec_res[18];

  logic [31:0] m_regs [32];
  int          m_pc;

  task automatic set_r(int idx, kind_e k, int rd, int rs1, int rs2);
    p_kind[idx] = k; p_rd[idx] = rd; p_rs1[idx] = rs1; p_rs2[idx] = rs2;
    p_isimm[idx] = 1'b0; p_imm[idx] = '0;
  endtask

  task automatic set_i(int idx, kind_e k, int rd, int rs1, int imm);
    p_kind[idx] = k; p_rd[idx] = rd; p_rs1[idx] = rs1; p_rs2[idx] = 0;
    p_isimm[idx] = 1'b1; p_imm[idx] = 32'(imm);
  endtask

  task automatic init_program();
    for (int i = 0; i < 32; i++) set_i(i, K_ADD, 0, 0, 0);
    set_r(0,  K_AND,  1, 0, 0);
    set_i(1,  K_ADD,  1, 0, 3);
    set_i(2,  K_ADD,  2, 0, 2);
    set_r(3,  K_ADD,  3, 1, 1);
    set_r(4,  K_OR,   4, 3, 1);
    set_r(5,  K_SLL,  5, 2, 2);
    set_r(6,  K_ADD,  6, 4, 3);
    set_r(7,  K_AND,  7, 6, 5);
    set_r(8,  K_SUB,  8, 7, 5);
    set_r(9,  K_SRA,  9, 5, 2);
    set_i(10, K_OR,  10, 9, 5);
    set_r(11, K_SLT, 11, 9, 10);
    set_i(12, K_ADD, 12, 0, -14);
    set_r(13, K_SLTU,13, 9, 12);
    set_i(14, K_XOR, 14, 12, 'h725);
    set_i(15, K_SLT, 15, 14, 0);
    set_i(16, K_ADD, 16, 14, 590);
    set_i(17, K_SLL, 17, 1, 4);
    spec_res = '{32'd0, 32'd3, 32'd2, 32'd6, 32'd7, 32'd8, 32'd13, 32'd8, 32'd0,
                 32'd2, 32'd7, 32'd1, 32'hFFFF_FFF2, 32'd1, 32'hFFFF_F8D7, 32'd1,
                 32'hFFFF_FB25, 32'h30};
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = 0;
  endtask

  function automatic logic [31:0] model_exec(int idx);
    logic [31:0] a, b;
    a = m_regs[p_rs1[idx]];
    b = p_isimm[idx] ? p_imm[idx] : m_regs[p_rs2[idx]];
    case (p_kind[idx])
      K_ADD:  return a + b;
      K_SUB:  return a - b;
      K_SLL:  return a << (b % 32);
      K_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      K_SLTU: return (a < b) ? 32'd1 : 32'd0;
      K_XOR:  return a ^ b;
      K_SRL:  return a >> (b % 32);
      K_SRA:  return $unsigned($signed(a) >>> (b % 32));
      K_OR:   return a | b;
      K_AND:  return a & b;
      default: return '0;
    endcase
  endfunction

  // Compare the current cycle's res with the model, then retire the instruction.
  task automatic check_cycle(string name);
    logic [31:0] exp;
    int idx;
    idx = m_pc;
    exp = model_exec(idx);
    checks++;
    if (res !== exp) begin
      errors++;
      $display("FAIL %s addr=%0d res: got %h expected %h", name, idx, res, exp);
    end
    if (idx < 18) begin
      checks++;
      if (res !== spec_res[idx]) begin
        errors++;
        $display("FAIL %s_listed addr=%0d res: got %h expected %h", name, idx, res, spec_res[idx]);
      end
    end
    checks++;
    if (dut.regs_q[0] !== 32'd0) begin
      errors++;
      $display("FAIL %s_x0 addr=%0d x0: got %h expected 0", name, idx, dut.regs_q[0]);
    end
    if (p_rd[idx] != 0) m_regs[p_rd[idx]] = exp;
    m_pc = (m_pc + 1) % 32;
  endtask

  task automatic run_cycles(int n, string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      check_cycle(name);
    end
  endtask

  task automatic check_in_reset(string name);
    int bad;
    checks++;
    if (res !== 32'd0) begin
      errors++;
      $display("FAIL %s_res: got %h expected 0", name, res);
    end
    checks++;
    if (dut.pc_q !== '0) begin
      errors++;
      $display("FAIL %s_pc: got %h expected 0", name, dut.pc_q);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (dut.regs_q[i] !== 32'd0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_regs: got %0d nonzero registers expected 0", name, bad);
    end
  endtask

  // Release at a falling edge so the first instruction is sampled mid-cycle.
  task automatic release_reset(string name);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_cycle(name);
  endtask

  // Assert reset a random few ns after the mid-cycle sample, before the next rising edge.
  task automatic async_reset(string name, int hold);
    #($urandom_range(1, 2));
    rst = 1'b0;
    #1;
    check_in_reset(name);
    model_reset();
    repeat (hold) @(posedge clk);
    @(negedge clk); #1;
    check_in_reset({name, "_held"});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_in_reset("reset");
    release_reset("reset_first");
    run_cycles(3, "reset_start");
  endtask

  task automatic test_alu_r();
    run_cycles(8, "alu_r");
  endtask

  task automatic test_imm();
    run_cycles(6, "imm");
  endtask

  task automatic test_async_reset();
    run_cycles(14, "nop_tail");
    run_cycles(10, "wrap_to_9");
    async_reset("async_rst", 1);
    release_reset("async_restart");
    run_cycles(1, "async_restart");
  endtask

  task automatic test_wrap();
    int bad;
    run_cycles(40, "wrap");
    bad = 0;
    for (int i = 0; i < 32; i++) if (dut.regs_q[i] !== m_regs[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wrap_regfile: got %0d registers differing from model expected 0", bad);
    end
  endtask

  task automatic test_random_resets();
    for (int it = 0; it < 5; it++) begin
      run_cycles($urandom_range(1, 40), "rand_run");
      async_reset("rand_rst", $urandom_range(1, 3));
      release_reset("rand_restart");
    end
    run_cycles(20, "rand_tail");
  endtask

  initial begin
    init_program();
    test_reset();
    test_alu_r();
    test_imm();
    test_async_reset();
    test_wrap();
    test_random_resets();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
